// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'hbfc00000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'hbfc00380;
  localparam int unsigned INSN_SIZE     = 32'd4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic [PW:0]     count
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   sp_q, sp_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            empty_q, empty_d;
  logic [PW-1:0]   top_idx_s;

  assign top_idx_s = sp_q - {{(PW-1){1'b0}}, 1'b1};

  // Next stack state; push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push && pop && (cnt_q != {(PW+1){1'b0}})) begin
      mem_d[top_idx_s] = push_data;
    end else if (push) begin
      mem_d[sp_q] = push_data;
      sp_d        = sp_q + {{(PW-1){1'b0}}, 1'b1};
      if (cnt_q != (PW+1)'(DEPTH)) begin
        cnt_d = cnt_q + {{PW{1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && (cnt_q != {(PW+1){1'b0}})) begin
      sp_d  = top_idx_s;
      cnt_d = cnt_q - {{PW{1'b0}}, 1'b1};
    end else begin
      sp_d = sp_q;
    end
    empty_d = (cnt_d == {(PW+1){1'b0}});
  end

  // Pointer, occupancy and empty flag registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      sp_q    <= {PW{1'b0}};
      cnt_q   <= {(PW+1){1'b0}};
      empty_q <= 1'b1;
    end else begin
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  // Entry storage is only read while occupied, so it needs no reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign top   = mem_q[top_idx_s];
  assign empty = empty_q;
  assign count = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator with prioritised redirects, exception bubble and misalignment trap.
// Define PC_GEN_RAS_EN to include the return-address stack (pc_ras).
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(DEF_EXC_VEC),
  parameter int              ALIGN_BITS = 2,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            except,
  input  logic            eret,
  input  logic [XLEN-1:0] epc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            call,
  input  logic            ret,
  input  logic [XLEN-1:0] ret_pc,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            addr_err,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_SIZE);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            addr_err_q, addr_err_d;
  logic [XLEN-1:0] redir_tgt_s;
  logic [XLEN-1:0] seq_pc_s;
  logic            to_bubble_s;
  logic            ras_push_s, ras_pop_s, ras_call_s, ras_empty_s;
  logic [XLEN-1:0] ras_top_s;

  assign seq_pc_s = pc_q + STEP;

`ifdef PC_GEN_RAS_EN
  logic [$clog2(RAS_DEPTH):0] ras_count_unused_s;

  assign ras_call_s = call;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .reset     (reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (seq_pc_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .count     (ras_count_unused_s)
  );
`else
  logic ras_unused_s;

  assign ras_call_s   = 1'b0;
  assign ras_top_s    = {XLEN{1'b0}};
  assign ras_empty_s  = 1'b1;
  assign ras_unused_s = call ^ ras_push_s ^ ras_pop_s;
`endif

  // Next-pc selection; only the winning redirect's target is alignment-checked.
  always_comb begin
    pc_d        = pc_q;
    addr_err_d  = 1'b0;
    to_bubble_s = 1'b0;
    ras_push_s  = 1'b0;
    ras_pop_s   = 1'b0;
    if (eret) begin
      redir_tgt_s = epc;
    end else if (br_taken) begin
      redir_tgt_s = br_pc;
    end else begin
      redir_tgt_s = jump_pc;
    end

    if (except) begin
      pc_d        = EXC_VEC;
      to_bubble_s = 1'b1;
    end else if (eret || br_taken || jump) begin
      if ((redir_tgt_s & ALIGN_MASK) != {XLEN{1'b0}}) begin
        pc_d        = EXC_VEC;
        addr_err_d  = 1'b1;
        to_bubble_s = 1'b1;
      end else begin
        pc_d = redir_tgt_s;
      end
    end else if (ret) begin
      ras_push_s = ras_call_s;
      ras_pop_s  = !ras_empty_s;
      if (ras_empty_s) begin
        pc_d = ret_pc;
      end else begin
        pc_d = ras_top_s;
      end
    end else begin
      ras_push_s = ras_call_s;
      if (pc_valid_q && fetch_ready) begin
        pc_d = seq_pc_s;
      end else begin
        pc_d = pc_q;
      end
    end

    case (state_q)
      ST_BOOT:   state_d = to_bubble_s ? ST_BUBBLE : ST_RUN;
      ST_RUN:    state_d = to_bubble_s ? ST_BUBBLE : ST_RUN;
      ST_BUBBLE: state_d = to_bubble_s ? ST_BUBBLE : ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d == ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign addr_err  = addr_err_q;
  assign ras_empty = ras_empty_s;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic vs a queue-based model.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset, fetch_ready, except, eret, br_taken, jump, call, ret;
  logic [31:0] epc, br_pc, jump_pc, ret_pc;
  logic [31:0] pc;
  logic        pc_valid, addr_err, ras_empty;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] m_pc;
  logic        m_valid, m_err;
  logic [31:0] m_stack[$];

  always #5 CLK = ~CLK;

  pc_gen #(.XLEN(32), .RESET_VEC(32'hbfc00000), .EXC_VEC(32'hbfc00380),
           .ALIGN_BITS(2), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .fetch_ready(fetch_ready), .except(except),
    .eret(eret), .epc(epc), .br_taken(br_taken), .br_pc(br_pc),
    .jump(jump), .jump_pc(jump_pc), .call(call), .ret(ret), .ret_pc(ret_pc),
    .pc(pc), .pc_valid(pc_valid), .addr_err(addr_err), .ras_empty(ras_empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    fetch_ready = 1'b0; except = 1'b0; eret = 1'b0; br_taken = 1'b0;
    jump = 1'b0; call = 1'b0; ret = 1'b0;
    epc = 32'h0; br_pc = 32'h0; jump_pc = 32'h0; ret_pc = 32'h0;
  endtask

  // Advance one clock: predict from the rules, then compare all outputs.
  task automatic step(input string tag);
    logic [31:0] n_pc, t;
    logic        n_valid, n_err;
    n_err = 1'b0;
    n_valid = 1'b1;
    n_pc = m_pc;
    if (!reset) begin
      n_pc = 32'hbfc00000; n_valid = 1'b0;
      m_stack.delete();
    end else if (except) begin
      n_pc = 32'hbfc00380; n_valid = 1'b0;
    end else if (eret || br_taken || jump) begin
      t = eret ? epc : (br_taken ? br_pc : jump_pc);
      if (t % 4 != 0) begin
        n_pc = 32'hbfc00380; n_valid = 1'b0; n_err = 1'b1;
      end else begin
        n_pc = t;
      end
    end else if (ret) begin
      if (RAS_EN && m_stack.size() > 0) n_pc = m_stack.pop_back();
      else n_pc = ret_pc;
      if (RAS_EN && call) m_stack.push_back(m_pc + 32'd4);
    end else begin
      if (RAS_EN && call) begin
        m_stack.push_back(m_pc + 32'd4);
        if (m_stack.size() > DEPTH) m_stack.delete(0);
      end
      if (m_valid && fetch_ready) n_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    #1;
    m_pc = n_pc; m_valid = n_valid; m_err = n_err;
    check_eq({tag, ".pc"}, pc, m_pc);
    check_eq({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, m_valid});
    check_eq({tag, ".err"}, {31'd0, addr_err}, {31'd0, m_err});
    check_eq({tag, ".empty"}, {31'd0, ras_empty},
             {31'd0, (!RAS_EN) || (m_stack.size() == 0)});
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 9) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    logic [31:0] ret_exp [5];
    clear_inputs();
    reset = 1'b0;
    m_pc = 32'h0; m_valid = 1'b0; m_err = 1'b0;

    step("rst");
    check_eq("rst_pc", pc, 32'hbfc00000);
    check_eq("rst_valid", {31'd0, pc_valid}, 32'd0);

    // Boot: one invalid cycle, then the first accepted fetch.
    reset = 1'b1; fetch_ready = 1'b1;
    step("boot");
    check_eq("boot_pc", pc, 32'hbfc00000);
    step("seq");
    check_eq("seq_pc", pc, 32'hbfc00004);

    // Branch redirect under stall.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall");
    check_eq("stall_pc", pc, 32'hbfc00004);
    br_taken = 1'b1; br_pc = 32'h80001000;
    step("br");
    check_eq("br_pc", pc, 32'h80001000);
    clear_inputs();

    // Exception beats jump.
    except = 1'b1; jump = 1'b1; jump_pc = 32'h00000100;
    step("exc");
    check_eq("exc_pc", pc, 32'hbfc00380);
    check_eq("exc_bubble", {31'd0, pc_valid}, 32'd0);
    clear_inputs();
    step("exc_run");
    check_eq("exc_run_valid", {31'd0, pc_valid}, 32'd1);

    // Misaligned jump.
    jump = 1'b1; jump_pc = 32'h80000002;
    step("mis");
    check_eq("mis_err", {31'd0, addr_err}, 32'd1);
    check_eq("mis_pc", pc, 32'hbfc00380);
    clear_inputs();
    step("mis_end");
    check_eq("mis_err_end", {31'd0, addr_err}, 32'd0);

    // Five calls overflow a four-entry stack, then five returns.
    for (int i = 1; i <= 5; i++) begin
      jump = 1'b1; jump_pc = 32'(i) * 32'h100;
      step("cjmp");
      clear_inputs();
      call = 1'b1;
      step("call");
      call = 1'b0;
    end
    ret_exp[0] = RAS_EN ? 32'h00000504 : 32'hdead0000;
    ret_exp[1] = RAS_EN ? 32'h00000404 : 32'hdead0000;
    ret_exp[2] = RAS_EN ? 32'h00000304 : 32'hdead0000;
    ret_exp[3] = RAS_EN ? 32'h00000204 : 32'hdead0000;
    ret_exp[4] = 32'hdead0000;
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1; ret_pc = 32'hdead0000;
      step("ret");
      check_eq($sformatf("ret%0d_pc", i), pc, ret_exp[i]);
    end
    clear_inputs();

    // Sequential wrap at the top of the address space.
    jump = 1'b1; jump_pc = 32'hfffffffc;
    step("wjmp");
    clear_inputs();
    fetch_ready = 1'b1;
    step("wrap");
    check_eq("wrap_pc", pc, 32'h00000000);
    check_eq("wrap_err", {31'd0, addr_err}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) != 0);
      fetch_ready = ($urandom_range(0, 9) < 7);
      except      = ($urandom_range(0, 19) == 0);
      eret        = ($urandom_range(0, 19) == 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      jump        = ($urandom_range(0, 9) == 0);
      ret         = ($urandom_range(0, 6) == 0);
      call        = ($urandom_range(0, 5) == 0);
      epc = rand_tgt(); br_pc = rand_tgt(); jump_pc = rand_tgt(); ret_pc = rand_tgt();
      step("rnd");
    end

    // Reset overrides a simultaneous redirect.
    reset = 1'b0; jump = 1'b1; jump_pc = 32'h00001000; except = 1'b0;
    step("rst_mid");
    check_eq("rst_mid_pc", pc, 32'hbfc00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
